// File: rtl/chip8_blitter.sv
// chip8_blitter: XOR sprite draw (8xN / 16x16) and full-screen clear engine
// for the CHIP-8 core. Reads sprite bytes from program RAM one cycle after
// presenting the address, walks one pixel per cycle over the VRAM pixel port
// and reports whether any lit pixel was turned off (VF collision).
module chip8_blitter #(
    parameter int HRES_W = 7,
    parameter int VRES_W = 6,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [7:0]        sprite_x,
    input  logic [7:0]        sprite_y,
    input  logic [3:0]        sprite_rows,
    input  logic [ADDR_W-1:0] sprite_addr,
    input  logic              wide,
    input  logic              wrap_mode,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic [HRES_W-1:0] vram_hpos,
    output logic [VRES_W-1:0] vram_vpos,
    input  logic [1:0]        vram_pixelo,
    output logic [1:0]        vram_pixeli,
    output logic              vram_we
);

    localparam int CLR_W = HRES_W + VRES_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR0 = 3'd1;
    localparam logic [2:0] S_ADDR1 = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_PIXEL = 3'd4;
    localparam logic [2:0] S_CLEAR = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [HRES_W-1:0] x0_q, x0_d;
    logic [VRES_W-1:0] y0_q, y0_d;
    logic [4:0]        rows_q, rows_d;      // up to 16 rows, so one bit wider than row_q
    logic [3:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic              wide_q, wide_d;
    logic              wrap_q, wrap_d;
    logic              coll_q, coll_d;
    logic [15:0]       shift_q, shift_d;    // sprite row, current pixel always in bit 15
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CLR_W-1:0]  clr_q, clr_d;        // {vpos, hpos} raster counter for clears

    logic [HRES_W:0]   px;
    logic [VRES_W:0]   py;
    logic              in_bounds;
    logic              pix_on;
    logic              pix_lit;
    logic              last_col;
    logic              last_row;
    logic              unused_coord_bits;

    // The extra top bit of px/py flags a pixel that ran off the right/bottom edge.
    assign px        = {1'b0, x0_q} + {{(HRES_W-3){1'b0}}, col_q};
    assign py        = {1'b0, y0_q} + {{(VRES_W-3){1'b0}}, row_q};
    assign in_bounds = wrap_q | ~(px[HRES_W] | py[VRES_W]);
    assign pix_on    = shift_q[15];
    assign pix_lit   = (vram_pixelo != 2'b00);
    assign last_col  = wide_q ? (col_q == 4'd15) : (col_q == 4'd7);
    assign last_row  = (({1'b0, row_q}) + 5'd1) == rows_q;

    // Coordinate bits above the display width are dropped by the modulo.
    assign unused_coord_bits = ^{sprite_x, sprite_y};

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign collision = coll_q;
    assign ram_addr  = addr_q;

    // Next-state logic: sequencing, counters, sprite shift register and collision.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        rows_d  = rows_q;
        row_d   = row_q;
        col_d   = col_q;
        wide_d  = wide_q;
        wrap_d  = wrap_q;
        coll_d  = coll_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        clr_d   = clr_q;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    coll_d  = 1'b0;
                    clr_d   = '0;
                    state_d = S_CLEAR;
                end else if (start) begin
                    coll_d  = 1'b0;
                    row_d   = 4'd0;
                    x0_d    = sprite_x[HRES_W-1:0];
                    y0_d    = sprite_y[VRES_W-1:0];
                    rows_d  = wide ? 5'd16 : {1'b0, sprite_rows};
                    wide_d  = wide;
                    wrap_d  = wrap_mode;
                    addr_d  = sprite_addr;
                    state_d = (!wide && sprite_rows == 4'd0) ? S_DONE : S_ADDR0;
                end
            end
            S_ADDR0: begin
                if (wide_q) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_ADDR1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_ADDR1: begin
                shift_d[15:8] = ram_dout;
                state_d       = S_LOAD;
            end
            S_LOAD: begin
                if (wide_q) shift_d[7:0] = ram_dout;
                else        shift_d      = {ram_dout, 8'h00};
                col_d   = 4'd0;
                state_d = S_PIXEL;
            end
            S_PIXEL: begin
                shift_d = {shift_q[14:0], 1'b0};
                col_d   = col_q + 4'd1;
                if (in_bounds && pix_on && pix_lit) coll_d = 1'b1;
                if (last_col) begin
                    if (last_row) begin
                        state_d = S_DONE;
                    end else begin
                        // Narrow rows are consecutive bytes; wide rows already sit on the low byte.
                        row_d   = row_q + 4'd1;
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_ADDR0;
                    end
                end
            end
            S_CLEAR: begin
                clr_d = clr_q + CLR_W'(1);
                if (&clr_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // VRAM port: driven only while drawing or clearing, idle-zero otherwise.
    always_comb begin
        vram_we     = 1'b0;
        vram_pixeli = 2'b00;
        vram_hpos   = '0;
        vram_vpos   = '0;
        if (state_q == S_PIXEL) begin
            vram_hpos = px[HRES_W-1:0];
            vram_vpos = py[VRES_W-1:0];
            if (in_bounds && pix_on) begin
                vram_we     = 1'b1;
                vram_pixeli = pix_lit ? 2'b00 : 2'b11;
            end
        end else if (state_q == S_CLEAR) begin
            vram_hpos = clr_q[HRES_W-1:0];
            vram_vpos = clr_q[CLR_W-1:HRES_W];
            vram_we   = 1'b1;
        end
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            rows_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wide_q  <= 1'b0;
            wrap_q  <= 1'b0;
            coll_q  <= 1'b0;
            shift_q <= '0;
            addr_q  <= '0;
            clr_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            rows_q  <= rows_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wide_q  <= wide_d;
            wrap_q  <= wrap_d;
            coll_q  <= coll_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            clr_q   <= clr_d;
        end
    end

endmodule

// File: tb/tb_chip8_blitter.sv
// Self-checking bench for chip8_blitter: RAM and VRAM models, a scoreboard
// of expected VRAM writes filled by a behavioural model of each operation
// and drained as the DUT writes, plus per-scenario timing/flag checks.
module tb_chip8_blitter;

    localparam int HRES = 128;
    localparam int VRES = 64;

    typedef struct packed {
        logic [6:0] h;
        logic [5:0] v;
        logic [1:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  sprite_x = '0;
    logic [7:0]  sprite_y = '0;
    logic [3:0]  sprite_rows = '0;
    logic [11:0] sprite_addr = '0;
    logic        wide = 1'b0;
    logic        wrap_mode = 1'b0;
    logic        busy, done, collision;
    logic [11:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [6:0]  vram_hpos;
    logic [5:0]  vram_vpos;
    logic [1:0]  vram_pixelo, vram_pixeli;
    logic        vram_we;

    logic [7:0]  mem    [0:4095];
    logic [1:0]  vram   [0:HRES-1][0:VRES-1];
    logic [1:0]  shadow [0:HRES-1][0:VRES-1];

    wr_t         exp_q[$];
    logic [11:0] addr_log[$];
    wr_t         mon_e;
    int          n_tests = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    bit          addr_log_en = 1'b0;
    logic [11:0] addr_prev = '0;

    chip8_blitter #(.HRES_W(7), .VRES_W(6), .ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_rows(sprite_rows),
        .sprite_addr(sprite_addr), .wide(wide), .wrap_mode(wrap_mode),
        .busy(busy), .done(done), .collision(collision),
        .ram_addr(ram_addr), .ram_dout(ram_dout),
        .vram_hpos(vram_hpos), .vram_vpos(vram_vpos),
        .vram_pixelo(vram_pixelo), .vram_pixeli(vram_pixeli), .vram_we(vram_we)
    );

    always #5 clk = ~clk;

    // Synchronous RAM read and VRAM pixel memory (wiped while reset is held).
    assign vram_pixelo = vram[vram_hpos][vram_vpos];
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (!rst_n) begin
            for (int h = 0; h < HRES; h++)
                for (int v = 0; v < VRES; v++) vram[h][v] <= 2'b00;
        end else if (vram_we) begin
            vram[vram_hpos][vram_vpos] <= vram_pixeli;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Scoreboard drain: each DUT write must match the next predicted write.
    always @(negedge clk) begin
        if (vram_we) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL vram_write: got unexpected write h=%0d v=%0d d=%0d, expected none",
                         vram_hpos, vram_vpos, vram_pixeli);
            end else begin
                mon_e = exp_q.pop_front();
                if ({vram_hpos, vram_vpos, vram_pixeli} !== mon_e) begin
                    n_fail++;
                    $display("FAIL vram_write: got h=%0d v=%0d d=%0d, expected h=%0d v=%0d d=%0d",
                             vram_hpos, vram_vpos, vram_pixeli, mon_e.h, mon_e.v, mon_e.d);
                end
            end
        end
        if (addr_log_en && ram_addr !== addr_prev) begin
            addr_log.push_back(ram_addr);
            addr_prev = ram_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lit_count();
        int n = 0;
        for (int h = 0; h < HRES; h++)
            for (int v = 0; v < VRES; v++)
                if (vram[h][v] != 2'b00) n++;
        return n;
    endfunction

    // Behavioural model of a sprite draw: pushes expected writes, updates shadow screen.
    task automatic predict_draw(input int x, input int y, input int n, input int base,
                                input bit w, input bit wr);
        int rows, width, px, py, h, v;
        logic [15:0] bits;
        logic [1:0] old, nd;
        wr_t e;
        rows  = w ? 16 : n;
        width = w ? 16 : 8;
        for (int r = 0; r < rows; r++) begin
            bits = w ? {mem[12'(base + 2*r)], mem[12'(base + 2*r + 1)]}
                     : {mem[12'(base + r)], 8'h00};
            for (int c = 0; c < width; c++) begin
                px = (x % HRES) + c;
                py = (y % VRES) + r;
                if (bits[15-c] && (wr || (px < HRES && py < VRES))) begin
                    h   = px % HRES;
                    v   = py % VRES;
                    old = shadow[h][v];
                    nd  = (old != 2'b00) ? 2'b00 : 2'b11;
                    shadow[h][v] = nd;
                    e.h = 7'(h); e.v = 6'(v); e.d = nd;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic predict_clear();
        wr_t e;
        for (int v = 0; v < VRES; v++)
            for (int h = 0; h < HRES; h++) begin
                shadow[h][v] = 2'b00;
                e.h = 7'(h); e.v = 6'(v); e.d = 2'b00;
                exp_q.push_back(e);
            end
    endtask

    // Launch one operation and count cycles from the accepting edge to done.
    task automatic run_op(input bit is_clear, input int x, input int y, input int n,
                          input int base, input bit w, input bit wr, input int limit,
                          input int inject_at, output int cycles, output bit busy1,
                          output bit busy_done);
        @(negedge clk);
        clear = is_clear; start = !is_clear;
        sprite_x = 8'(x); sprite_y = 8'(y); sprite_rows = 4'(n);
        sprite_addr = 12'(base); wide = w; wrap_mode = wr;
        @(posedge clk);
        #1 start = 1'b0; clear = 1'b0;
        cycles = 0; busy1 = 1'b0; busy_done = 1'b1;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) busy1 = busy;
            if (inject_at > 0 && cycles == inject_at) begin
                start = 1'b1; clear = 1'b1; sprite_x = 8'd0; sprite_y = 8'd0;
                sprite_rows = 4'd1; wide = 1'b1; wrap_mode = 1'b1;
            end
            if (inject_at > 0 && cycles == inject_at + 1) begin
                start = 1'b0; clear = 1'b0;
            end
            if (done) begin
                busy_done = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int h = 0; h < HRES; h++)
            for (int v = 0; v < VRES; v++) shadow[h][v] = 2'b00;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, collision, vram_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/coll/we=%b, expected 0000",
                     {busy, done, collision, vram_we});
        end
        n_tests++;
        if (ram_addr !== 12'h000) begin
            n_fail++; $display("FAIL reset_ram_addr: got %h expected 000", ram_addr);
        end
        n_tests++;
        if ({vram_hpos, vram_vpos, vram_pixeli} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_vram_port: got h=%0d v=%0d d=%0d expected all 0",
                     vram_hpos, vram_vpos, vram_pixeli);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_narrow(input string tag, input int exp_coll, input int exp_lit);
        int cyc, w0, hits;
        bit b1, bd;
        int hs[6] = '{10, 11, 12, 13, 10, 17};
        int vs[6] = '{5, 5, 5, 5, 6, 6};
        mem[12'h300] = 8'hF0; mem[12'h301] = 8'h81;
        predict_draw(10, 5, 2, 'h300, 1'b0, 1'b0);
        w0 = wr_cnt;
        run_op(1'b0, 10, 5, 2, 'h300, 1'b0, 1'b0, 60, 0, cyc, b1, bd);
        n_tests++;
        if (cyc !== 21) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected 21", tag, cyc); end
        n_tests++;
        if (b1 !== 1'b1 || bd !== 1'b0) begin
            n_fail++; $display("FAIL %s_busy: got %b/%b expected 1/0", tag, b1, bd);
        end
        n_tests++;
        if (collision !== 1'(exp_coll)) begin
            n_fail++; $display("FAIL %s_collision: got %b expected %0d", tag, collision, exp_coll);
        end
        n_tests++;
        if (wr_cnt - w0 !== 6) begin n_fail++; $display("FAIL %s_writes: got %0d expected 6", tag, wr_cnt - w0); end
        hits = 0;
        for (int i = 0; i < 6; i++) if (vram[hs[i]][vs[i]] == 2'b11) hits++;
        n_tests++;
        if (hits !== (exp_lit > 0 ? 6 : 0) || lit_count() !== exp_lit) begin
            n_fail++;
            $display("FAIL %s_pixels: got %0d listed/%0d total lit, expected %0d total", tag, hits, lit_count(), exp_lit);
        end
        n_tests++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL %s_pending: got %0d left expected 0", tag, exp_q.size()); end
    endtask

    task automatic test_zero_rows();
        int cyc, w0;
        bit b1, bd;
        w0 = wr_cnt;
        run_op(1'b0, 20, 20, 0, 'h300, 1'b0, 1'b0, 20, 0, cyc, b1, bd);
        n_tests++;
        if (cyc !== 1) begin n_fail++; $display("FAIL zero_rows_done_cycle: got %0d expected 1", cyc); end
        n_tests++;
        if (wr_cnt !== w0 || collision !== 1'b0) begin
            n_fail++; $display("FAIL zero_rows_effect: got %0d writes coll=%b expected 0 writes coll=0", wr_cnt - w0, collision);
        end
    endtask

    task automatic test_clip_wrap();
        int cyc, w0;
        bit b1, bd;
        mem[12'h310] = 8'hFF; mem[12'h311] = 8'hFF;
        for (int m = 0; m < 2; m++) begin
            predict_draw(126, 63, 2, 'h310, 1'b0, m[0]);
            w0 = wr_cnt;
            run_op(1'b0, 126, 63, 2, 'h310, 1'b0, m[0], 60, 0, cyc, b1, bd);
            n_tests++;
            if (cyc !== 21) begin n_fail++; $display("FAIL clip_wrap%0d_done_cycle: got %0d expected 21", m, cyc); end
            n_tests++;
            if (wr_cnt - w0 !== (m == 0 ? 2 : 16)) begin
                n_fail++; $display("FAIL clip_wrap%0d_writes: got %0d expected %0d", m, wr_cnt - w0, m == 0 ? 2 : 16);
            end
            n_tests++;
            if (collision !== m[0]) begin n_fail++; $display("FAIL clip_wrap%0d_collision: got %b expected %0d", m, collision, m); end
            n_tests++;
            if (lit_count() !== (m == 0 ? 2 : 14) || exp_q.size() !== 0) begin
                n_fail++;
                $display("FAIL clip_wrap%0d_pixels: got %0d lit %0d pending expected %0d lit 0 pending",
                         m, lit_count(), exp_q.size(), m == 0 ? 2 : 14);
            end
        end
    endtask

    task automatic test_clear();
        int cyc, w0;
        bit b1, bd;
        predict_clear();
        w0 = wr_cnt;
        run_op(1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 8300, 0, cyc, b1, bd);
        n_tests++;
        if (cyc !== 8193) begin n_fail++; $display("FAIL clear_done_cycle: got %0d expected 8193", cyc); end
        n_tests++;
        if (wr_cnt - w0 !== 8192 || exp_q.size() !== 0) begin
            n_fail++; $display("FAIL clear_writes: got %0d writes %0d pending expected 8192/0", wr_cnt - w0, exp_q.size());
        end
        n_tests++;
        if (collision !== 1'b0 || lit_count() !== 0 || bd !== 1'b0) begin
            n_fail++; $display("FAIL clear_result: got coll=%b lit=%0d busy=%b expected 0/0/0", collision, lit_count(), bd);
        end
    endtask

    task automatic test_wide();
        int cyc, w0, bad;
        bit b1, bd;
        for (int r = 0; r < 16; r++) begin
            mem[12'(12'h340 + 2*r)]     = (r % 2 == 0) ? 8'hAA : 8'h55;
            mem[12'(12'h340 + 2*r + 1)] = (r % 2 == 0) ? 8'hAA : 8'h55;
        end
        predict_draw(0, 0, 0, 'h340, 1'b1, 1'b0);
        addr_log.delete();
        addr_prev = ram_addr;
        addr_log_en = 1'b1;
        w0 = wr_cnt;
        run_op(1'b0, 0, 0, 5, 'h340, 1'b1, 1'b0, 400, 0, cyc, b1, bd);
        addr_log_en = 1'b0;
        n_tests++;
        if (cyc !== 305) begin n_fail++; $display("FAIL wide_done_cycle: got %0d expected 305", cyc); end
        n_tests++;
        if (wr_cnt - w0 !== 128 || collision !== 1'b0) begin
            n_fail++; $display("FAIL wide_writes: got %0d coll=%b expected 128 coll=0", wr_cnt - w0, collision);
        end
        bad = 0;
        for (int h = 0; h < 16; h++)
            for (int v = 0; v < 16; v++)
                if (vram[h][v] !== (((h + v) % 2 == 0) ? 2'b11 : 2'b00)) bad++;
        n_tests++;
        if (bad !== 0 || lit_count() !== 128) begin
            n_fail++; $display("FAIL wide_checker: got %0d wrong pixels %0d lit expected 0/128", bad, lit_count());
        end
        n_tests++;
        if (addr_log.size() !== 32) begin
            n_fail++; $display("FAIL wide_addr_count: got %0d expected 32", addr_log.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                n_tests++;
                if (addr_log[i] !== 12'(12'h340 + i)) begin
                    n_fail++; $display("FAIL wide_addr_%0d: got %h expected %h", i, addr_log[i], 12'(12'h340 + i));
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc, w0, stray;
        bit b1, bd;
        mem[12'h302] = 8'h3C;
        predict_draw(40, 20, 3, 'h300, 1'b0, 1'b0);
        w0 = wr_cnt;
        run_op(1'b0, 40, 20, 3, 'h300, 1'b0, 1'b0, 80, 5, cyc, b1, bd);
        n_tests++;
        if (cyc !== 31) begin n_fail++; $display("FAIL busy_ignore_done_cycle: got %0d expected 31", cyc); end
        n_tests++;
        if (wr_cnt - w0 !== 10 || exp_q.size() !== 0 || collision !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore_writes: got %0d writes %0d pending coll=%b expected 10/0/0",
                     wr_cnt - w0, exp_q.size(), collision);
        end
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || done) stray++;
        end
        n_tests++;
        if (stray !== 0) begin n_fail++; $display("FAIL busy_ignore_idle: got %0d active cycles expected 0", stray); end
    endtask

    task automatic test_reset_mid();
        int w0;
        for (int r = 0; r < 4; r++) mem[12'(12'h320 + r)] = 8'hFF;
        predict_draw(60, 30, 4, 'h320, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; sprite_x = 8'd60; sprite_y = 8'd30; sprite_rows = 4'd4;
        sprite_addr = 12'h320; wide = 1'b0; wrap_mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (vram_we !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre_we: got %b expected 1", vram_we); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({vram_we, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_immediate: got we/busy/done=%b expected 000", {vram_we, busy, done});
        end
        w0 = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (wr_cnt !== w0) begin n_fail++; $display("FAIL reset_mid_writes: got %0d expected 0", wr_cnt - w0); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, collision, vram_we} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mid_idle: got %b expected 0000", {busy, done, collision, vram_we});
        end
    endtask

    initial begin
        test_reset();
        test_narrow("narrow", 0, 6);
        test_narrow("redraw", 1, 0);
        test_zero_rows();
        test_clip_wrap();
        test_clear();
        test_wide();
        test_busy_ignore();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
